// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM access point shared by display-fetch reads and CPU accesses,
// video priority with a bounded CPU starvation count, level req / one-cycle ack handshake.
module vram_arbiter #(
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 8,
    parameter int MEM_LATENCY    = 2,
    parameter int CPU_STARVE_MAX = 4
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_rd_req,
    output logic              vid_rd_ack,
    output logic [DATA_W-1:0] vid_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [2:0] LAT_LAST   = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(CPU_STARVE_MAX);

    state_t            state_q;
    logic [2:0]        lat_q;
    logic [3:0]        starve_q, starve_d;
    logic              sel_cpu_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q, vid_ack_q, cpu_ack_q;
    logic [DATA_W-1:0] mem_wdata_q, vid_data_q, cpu_rdata_q;
    logic              arb, vid_el, cpu_el, cpu_win, vid_win;

    // A port whose ack is high this cycle still shows its old req; it is not eligible.
    always_comb begin
        arb      = state_q != READ;
        vid_el   = arb && vid_rd_req && !vid_ack_q;
        cpu_el   = arb && cpu_req && !cpu_ack_q;
        cpu_win  = cpu_el && (!vid_el || starve_q == STARVE_MAX);
        vid_win  = vid_el && !cpu_win;
        starve_d = (!cpu_req || cpu_win) ? 4'd0 :
                   (vid_win && starve_q != STARVE_MAX) ? starve_q + 4'd1 : starve_q;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            sel_cpu_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            starve_q  <= starve_d;
            mem_we_q  <= 1'b0;
            vid_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            if (state_q == READ) begin
                if (lat_q == 3'd0) begin
                    state_q   <= IDLE;
                    vid_ack_q <= !sel_cpu_q;
                    cpu_ack_q <= sel_cpu_q;
                    if (sel_cpu_q) cpu_rdata_q <= mem_rdata;
                    else vid_data_q <= mem_rdata;
                end else begin
                    lat_q <= lat_q - 3'd1;
                end
            end else if (vid_win || cpu_win) begin
                sel_cpu_q  <= cpu_win;
                mem_addr_q <= cpu_win ? cpu_addr : vid_addr;
                lat_q      <= LAT_LAST;
                state_q    <= (cpu_win && cpu_wr) ? WRITE : READ;
                mem_we_q   <= cpu_win && cpu_wr;
                cpu_ack_q  <= cpu_win && cpu_wr;
                if (cpu_win && cpu_wr) mem_wdata_q <= cpu_wdata;
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign vid_rd_ack = vid_ack_q;
    assign vid_data   = vid_data_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a transaction-level
// model that schedules acks and read results from the arbitration rules.
module tb_vram_arbiter;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int L = 2;
    localparam int SMAX = 4;

    logic          sys_clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] vid_addr, cpu_addr, mem_addr;
    logic          vid_rd_req, vid_rd_ack, cpu_req, cpu_wr, cpu_ack, mem_we;
    logic [DW-1:0] vid_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;

    int passed = 0;
    int total = 0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L), .CPU_STARVE_MAX(SMAX)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .vid_addr(vid_addr), .vid_rd_req(vid_rd_req), .vid_rd_ack(vid_rd_ack), .vid_data(vid_data),
        .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ {a[11:8], 4'h0};
    endfunction

    // RAM: address registered once, data valid the following cycle.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [AW-1:0] rd_addr_q = '0;
    initial for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(AW'(i));
    always @(posedge sys_clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        rd_addr_q <= mem_addr;
    end
    assign mem_rdata = ram[rd_addr_q];

    // Reference model: memory contents as the requesters should see them, plus scheduled events.
    logic [DW-1:0] shadow [int];
    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
    endfunction

    int cyc = 0, idle_at = 0, vack_at = -1, cack_at = -1, we_at = -1, starve = 0;
    logic          e_vack = 0, e_cack = 0, e_we = 0;
    logic [DW-1:0] vres = 0, cres = 0, e_vdata = 0, e_cdata = 0, e_wdata = 0;
    logic [AW-1:0] e_addr = 0;

    initial forever begin
        bit v_el, c_el, vw, cw;
        @(posedge sys_clk or negedge reset_n);
        if (!reset_n) begin
            idle_at = cyc; vack_at = -1; cack_at = -1; we_at = -1; starve = 0;
            e_vack = 0; e_cack = 0; e_we = 0; e_vdata = 0; e_cdata = 0; e_addr = 0;
        end else begin
            vw = 0; cw = 0;
            if (cyc >= idle_at) begin
                v_el = vid_rd_req && cyc != vack_at;
                c_el = cpu_req && cyc != cack_at;
                cw = c_el && (!v_el || starve == SMAX);
                vw = v_el && !cw;
            end
            if (vw) begin
                e_addr = vid_addr; vres = rd(vid_addr); vack_at = cyc + L + 1; idle_at = vack_at;
            end
            if (cw && cpu_wr) begin
                e_addr = cpu_addr; shadow[int'(cpu_addr)] = cpu_wdata; e_wdata = cpu_wdata;
                cack_at = cyc + 1; we_at = cyc + 1; idle_at = cyc + 1;
            end else if (cw) begin
                e_addr = cpu_addr; cres = rd(cpu_addr); cack_at = cyc + L + 1; idle_at = cack_at;
            end
            starve = (!cpu_req || cw) ? 0 : (vw && starve < SMAX) ? starve + 1 : starve;
            cyc++;
            e_vack = cyc == vack_at;
            e_cack = cyc == cack_at;
            e_we = cyc == we_at;
            if (e_vack) e_vdata = vres;
            if (e_cack && !e_we) e_cdata = cres;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        total++; if ({vid_rd_ack, cpu_ack, mem_we} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {vid_rd_ack, cpu_ack, mem_we}); else passed++;
        total++; if ({vid_data, cpu_rdata} !== 16'h0) $display("FAIL reset_data got %h want 0000", {vid_data, cpu_rdata}); else passed++;
        total++; if ({mem_addr, mem_wdata} !== 21'h0) $display("FAIL reset_mem got %h want 0", {mem_addr, mem_wdata}); else passed++;
        reset_n = 1;
        tick();
    endtask

    task automatic test_single_video_read();
        int acks = 0;
        vid_addr = 13'h0401; vid_rd_req = 1;
        tick();
        total++; if (mem_addr !== 13'h0401) $display("FAIL vread_addr got %h want 0401", mem_addr); else passed++;
        tick();
        total++; if (vid_rd_ack !== 1'b0) $display("FAIL vread_early_ack got %b want 0", vid_rd_ack); else passed++;
        tick();
        total++; if (vid_rd_ack !== 1'b1) $display("FAIL vread_ack got %b want 1", vid_rd_ack); else passed++;
        total++; if (vid_data !== 8'h41) $display("FAIL vread_data got %h want 41", vid_data); else passed++;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) vid_rd_req = 0;
            acks += int'(vid_rd_ack);
            total++; if (vid_data !== 8'h41) $display("FAIL vread_hold got %h want 41", vid_data); else passed++;
        end
        total++; if (acks != 0) $display("FAIL vread_spurious_ack got %0d want 0", acks); else passed++;
    endtask

    task automatic test_write_then_read();
        int tv = -1;
        bit vs = 0;
        cpu_addr = 13'h0208; cpu_wr = 1; cpu_wdata = 8'h5A; cpu_req = 1;
        tick();
        total++; if ({mem_we, cpu_ack} !== 2'b11) $display("FAIL wr_strobe got %b want 11", {mem_we, cpu_ack}); else passed++;
        total++; if ({mem_addr, mem_wdata} !== {13'h0208, 8'h5A}) $display("FAIL wr_bus got %h/%h want 0208/5a", mem_addr, mem_wdata); else passed++;
        tick();
        cpu_req = 0;
        total++; if ({mem_we, cpu_ack} !== 2'b00) $display("FAIL wr_single got %b want 00", {mem_we, cpu_ack}); else passed++;
        total++; if (ram[13'h0208] !== 8'h5A) $display("FAIL wr_ram got %h want 5a", ram[13'h0208]); else passed++;
        vid_addr = 13'h0208; vid_rd_req = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (vid_rd_ack && tv < 0) tv = c;
            vid_rd_req = vid_rd_req && !vs; vs = vid_rd_ack;
        end
        total++; if (tv != L + 1) $display("FAIL wr_rd_ack_cycle got %0d want %0d", tv, L + 1); else passed++;
        total++; if (vid_data !== 8'h5A) $display("FAIL wr_rd_data got %h want 5a", vid_data); else passed++;
    endtask

    task automatic test_simultaneous();
        int tv = -1, tc = -1;
        bit vs = 0, cs = 0;
        logic [AW-1:0] va = 13'h1F00, ca = 13'h0123;
        vid_addr = va; cpu_addr = ca; cpu_wr = 0; vid_rd_req = 1; cpu_req = 1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (vid_rd_ack && tv < 0) tv = c;
            if (cpu_ack && tc < 0) tc = c;
            vid_rd_req = vid_rd_req && !vs; vs = vid_rd_ack;
            cpu_req = cpu_req && !cs; cs = cpu_ack;
        end
        total++; if (tv != L + 1) $display("FAIL sim_vid_first got %0d want %0d", tv, L + 1); else passed++;
        total++; if (!(tc > tv && tc - tv <= L + 1)) $display("FAIL sim_cpu_after got %0d want in (%0d,%0d]", tc, tv, tv + L + 1); else passed++;
        total++; if (vid_data !== rd(va)) $display("FAIL sim_vid_data got %h want %h", vid_data, rd(va)); else passed++;
        total++; if (cpu_rdata !== rd(ca)) $display("FAIL sim_cpu_data got %h want %h", cpu_rdata, rd(ca)); else passed++;
    endtask

    task automatic test_starvation();
        int vrun = 0, vmax = 0, nv = 0, nc = 0;
        bit vs = 0;
        cpu_addr = 13'h0777; cpu_wr = 0; cpu_req = 1;
        vid_addr = 13'h0100; vid_rd_req = 1;
        for (int c = 0; c < 80; c++) begin
            tick();
            total++; if ({vid_rd_ack, cpu_ack} !== {e_vack, e_cack}) $display("FAIL starve_acks got %b want %b", {vid_rd_ack, cpu_ack}, {e_vack, e_cack}); else passed++;
            if (vid_rd_ack) begin
                nv++; vrun++; vmax = vrun > vmax ? vrun : vmax;
                total++; if (vid_data !== rd(vid_addr)) $display("FAIL starve_vid_data got %h want %h", vid_data, rd(vid_addr)); else passed++;
            end
            if (cpu_ack) begin
                nc++; vrun = 0;
                total++; if (cpu_rdata !== rd(13'h0777)) $display("FAIL starve_cpu_data got %h want %h", cpu_rdata, rd(13'h0777)); else passed++;
            end
            if (!vid_rd_req) begin vid_addr = vid_addr + 13'd1; vid_rd_req = 1; end
            else if (vs) vid_rd_req = 0;
            vs = vid_rd_ack;
        end
        total++; if (vmax > SMAX) $display("FAIL starve_bound got %0d want <=%0d", vmax, SMAX); else passed++;
        total++; if (nc < 5 || nv < 5) $display("FAIL starve_progress got cpu=%0d vid=%0d want >=5 each", nc, nv); else passed++;
        vid_rd_req = 0; cpu_req = 0;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid_read();
        int strobes = 0, tv = -1;
        bit vs = 0;
        vid_addr = 13'h0ABC; vid_rd_req = 1;
        tick();
        #2 reset_n = 0;
        #1;
        total++; if ({vid_rd_ack, cpu_ack, mem_we, mem_addr, mem_wdata, vid_data, cpu_rdata} !== 40'h0)
            $display("FAIL async_reset got %h want 0", {vid_rd_ack, cpu_ack, mem_we, mem_addr, mem_wdata, vid_data, cpu_rdata}); else passed++;
        vid_rd_req = 0;
        tick(); tick();
        reset_n = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            strobes += int'(vid_rd_ack) + int'(cpu_ack) + int'(mem_we);
        end
        total++; if (strobes != 0) $display("FAIL abort_silent got %0d want 0", strobes); else passed++;
        vid_rd_req = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (vid_rd_ack && tv < 0) tv = c;
            vid_rd_req = vid_rd_req && !vs; vs = vid_rd_ack;
        end
        total++; if (tv != L + 1) $display("FAIL post_reset_ack got %0d want %0d", tv, L + 1); else passed++;
        total++; if (vid_data !== rd(13'h0ABC)) $display("FAIL post_reset_data got %h want %h", vid_data, rd(13'h0ABC)); else passed++;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        return $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'(32'h0200 + $urandom_range(0, 7));
    endfunction

    task automatic test_random();
        bit vs = 0, cs = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            total++; if ({vid_rd_ack, cpu_ack, mem_we} !== {e_vack, e_cack, e_we}) $display("FAIL rnd_strobes c=%0d got %b want %b", c, {vid_rd_ack, cpu_ack, mem_we}, {e_vack, e_cack, e_we}); else passed++;
            total++; if (vid_data !== e_vdata) $display("FAIL rnd_vid_data c=%0d got %h want %h", c, vid_data, e_vdata); else passed++;
            total++; if (cpu_rdata !== e_cdata) $display("FAIL rnd_cpu_data c=%0d got %h want %h", c, cpu_rdata, e_cdata); else passed++;
            if (cyc < idle_at || e_we) begin
                total++; if (mem_addr !== e_addr) $display("FAIL rnd_mem_addr c=%0d got %h want %h", c, mem_addr, e_addr); else passed++;
            end
            if (e_we) begin
                total++; if (mem_wdata !== e_wdata) $display("FAIL rnd_mem_wdata c=%0d got %h want %h", c, mem_wdata, e_wdata); else passed++;
            end
            if (!vid_rd_req) begin
                if ($urandom_range(0, 2) == 0) begin vid_addr = pick_addr(); vid_rd_req = 1; end
            end else if (vs) vid_rd_req = 0;
            vs = vid_rd_ack;
            if (!cpu_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    cpu_addr = pick_addr(); cpu_wr = 1'($urandom_range(0, 1)); cpu_wdata = DW'($urandom); cpu_req = 1;
                end
            end else if (cs) cpu_req = 0;
            cs = cpu_ack;
        end
        vid_rd_req = 0; cpu_req = 0;
        repeat (8) tick();
    endtask

    initial begin
        reset_n = 0; vid_addr = '0; vid_rd_req = 0; cpu_addr = '0; cpu_req = 0; cpu_wr = 0; cpu_wdata = '0;
        test_reset();
        test_single_video_read();
        test_write_then_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
